// File: rtl/batch_key_events.sv
// batch_key_events
// Multi-key front end for the clock's user buttons. Every channel
// synchronises its raw active-low pin, debounces it, and reports one-cycle
// press, release, long-press and auto-repeat events. Channels are
// replicated by generate and share nothing but clk and rst_n.
//
// Ports:
//   clk           system clock
//   rst_n         asynchronous active-low reset, clears every channel
//   keys          raw key pins, 0 = pressed, idle 1
//   repeat_en     per-key auto-repeat enable, synchronous to clk
//   key_state     debounced level, 1 = pressed
//   press_pulse   one-cycle pulse per accepted press
//   release_pulse one-cycle pulse per accepted release
//   long_pulse    one-cycle pulse once a press has lasted LONG_CYCLES
//   repeat_pulse  one-cycle pulse every REPEAT_CYCLES after the long point
//
// All outputs are registered. They are computed from the filtered level
// and its next value. This gives the same cycle timing as a delayed-level
// edge detector, but with no combinational path to the pins.
module batch_key_events #(
  parameter int NUM_KEYS        = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int LONG_CYCLES     = 50000000,
  parameter int REPEAT_CYCLES   = 10000000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] keys,
  input  logic [NUM_KEYS-1:0] repeat_en,
  output logic [NUM_KEYS-1:0] key_state,
  output logic [NUM_KEYS-1:0] press_pulse,
  output logic [NUM_KEYS-1:0] release_pulse,
  output logic [NUM_KEYS-1:0] long_pulse,
  output logic [NUM_KEYS-1:0] repeat_pulse
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(LONG_CYCLES + 1);
  localparam int RW = $clog2(REPEAT_CYCLES + 1);

  localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] H_LONG = HW'(LONG_CYCLES);
  localparam logic [HW-1:0] H_PRE  = HW'(LONG_CYCLES - 1);
  localparam logic [RW-1:0] R_LAST = RW'(REPEAT_CYCLES - 1);

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
    logic          sync1_r;
    logic          sync2_r;
    logic          filt_r;
    logic          filt_nxt_s;
    logic [DW-1:0] dcnt_r;
    logic [DW-1:0] dcnt_nxt_s;
    logic [HW-1:0] hcnt_r;
    logic [RW-1:0] rcnt_r;
    logic          rep_active_s;
    logic          state_r;
    logic          press_r;
    logic          release_r;
    logic          long_r;
    logic          repeat_r;

    // Debounce: accept the sampled level only after DEBOUNCE_CYCLES
    // consecutive disagreeing samples. Any agreement restarts the count.
    always_comb begin
      filt_nxt_s = filt_r;
      dcnt_nxt_s = '0;
      if (sync2_r == filt_r) begin
        dcnt_nxt_s = '0;
      end else if (dcnt_r == D_LAST) begin
        filt_nxt_s = sync2_r;
        dcnt_nxt_s = '0;
      end else begin
        dcnt_nxt_s = dcnt_r + DW'(1);
      end
    end

    // Repeat timing runs only once the hold timer has saturated at the
    // long point, the key is still down, and repeat is enabled.
    always_comb begin
      rep_active_s = ~filt_r & (hcnt_r == H_LONG) & repeat_en[g];
    end

    // Synchroniser, filtered level and debounce counter.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync1_r <= 1'b1;
        sync2_r <= 1'b1;
        filt_r  <= 1'b1;
        dcnt_r  <= '0;
      end else begin
        sync1_r <= keys[g];
        sync2_r <= sync1_r;
        filt_r  <= filt_nxt_s;
        dcnt_r  <= dcnt_nxt_s;
      end
    end

    // Hold and repeat counters. hcnt is zero in the press-pulse cycle and
    // reaches LONG_CYCLES in the long-pulse cycle, where it saturates.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        hcnt_r <= '0;
        rcnt_r <= '0;
      end else begin
        if (filt_r) begin
          hcnt_r <= '0;
        end else if (hcnt_r != H_LONG) begin
          hcnt_r <= hcnt_r + HW'(1);
        end else begin
          hcnt_r <= hcnt_r;
        end
        if (!rep_active_s) begin
          rcnt_r <= '0;
        end else if (rcnt_r == R_LAST) begin
          rcnt_r <= '0;
        end else begin
          rcnt_r <= rcnt_r + RW'(1);
        end
      end
    end

    // Registered event outputs. A filtered release landing on the same
    // edge suppresses long and repeat pulses, so those never coincide
    // with release_pulse.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_r   <= 1'b0;
        press_r   <= 1'b0;
        release_r <= 1'b0;
        long_r    <= 1'b0;
        repeat_r  <= 1'b0;
      end else begin
        state_r   <= ~filt_nxt_s;
        press_r   <= filt_r & ~filt_nxt_s;
        release_r <= ~filt_r & filt_nxt_s;
        long_r    <= ~filt_r & ~filt_nxt_s & (hcnt_r == H_PRE);
        repeat_r  <= rep_active_s & ~filt_nxt_s & (rcnt_r == R_LAST);
      end
    end

    assign key_state[g]     = state_r;
    assign press_pulse[g]   = press_r;
    assign release_pulse[g] = release_r;
    assign long_pulse[g]    = long_r;
    assign repeat_pulse[g]  = repeat_r;
  end

endmodule

// File: tb/tb_batch_key_events.sv
// Directed bench for batch_key_events with DEBOUNCE=4, LONG=10, REPEAT=3.
// Loop index k counts posedges from the first edge that sees the new
// input. A key driven low before edge 0 is accepted at edge 5. Its press
// pulse is visible after edge 5, its long pulse after edge 15, and its
// repeats after edges 18, 21, ...
// Outputs are sampled on the negedge and packed as:
//   {key_state, press, release, long, repeat}.
module tb_batch_key_events;

  logic       clk;
  logic       rst_n;
  logic [3:0] keys;
  logic [3:0] repeat_en;
  logic [3:0] key_state;
  logic [3:0] press_pulse;
  logic [3:0] release_pulse;
  logic [3:0] long_pulse;
  logic [3:0] repeat_pulse;

  int total;
  int bad;

  batch_key_events #(
    .NUM_KEYS(4),
    .DEBOUNCE_CYCLES(4),
    .LONG_CYCLES(10),
    .REPEAT_CYCLES(3)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .keys(keys),
    .repeat_en(repeat_en),
    .key_state(key_state),
    .press_pulse(press_pulse),
    .release_pulse(release_pulse),
    .long_pulse(long_pulse),
    .repeat_pulse(repeat_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [19:0] observed();
    return {key_state, press_pulse, release_pulse, long_pulse, repeat_pulse};
  endfunction

  // True when k lies on a period-3 grid starting at first, up to last.
  function automatic logic on_grid(int k, int first, int last);
    return (k >= first) && (k <= last) && (((k - first) % 3) == 0);
  endfunction

  // Expected bits for one key: ks, press, release, long, repeat.
  function automatic logic [19:0] key_bits(int i, logic ks, logic pr,
                                           logic rl, logic lg, logic rp);
    logic [19:0] v;
    v = 20'h00000;
    v[16 + i] = ks;
    v[12 + i] = pr;
    v[8 + i]  = rl;
    v[4 + i]  = lg;
    v[i]      = rp;
    return v;
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    keys      = 4'hF;
    repeat_en = 4'h0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [19:0] act;
    rst_n     = 1'b0;
    keys      = 4'hF;
    repeat_en = 4'hF;
    repeat (2) @(negedge clk);
    act = observed();
    total++;
    if (act !== 20'h00000) begin
      bad++;
      $display("FAIL reset_hold got=%05h want=%05h", act, 20'h00000);
    end
    rst_n = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      act = observed();
      total++;
      if (act !== 20'h00000) begin
        bad++;
        $display("FAIL idle k=%0d got=%05h want=%05h", k, act, 20'h00000);
      end
    end
  endtask

  task automatic test_single_key();
    logic [19:0] act;
    logic [19:0] exp;
    apply_reset();
    repeat_en = 4'b0001;
    for (int k = 0; k <= 45; k++) begin
      keys[0] = (k <= 30) ? 1'b0 : 1'b1;
      @(negedge clk);
      exp = key_bits(0, (k >= 5 && k < 36), (k == 5), (k == 36), (k == 15),
                     on_grid(k, 18, 35));
      act = observed();
      total++;
      if (act !== exp) begin
        bad++;
        $display("FAIL single k=%0d got=%05h want=%05h", k, act, exp);
      end
    end
  endtask

  task automatic test_bounce();
    logic [19:0] act;
    logic [19:0] exp;
    logic        low;
    apply_reset();
    for (int k = 0; k <= 40; k++) begin
      low = (k <= 2) || (k >= 5 && k <= 7) || (k >= 10);
      keys[1] = ~low;
      @(negedge clk);
      exp = key_bits(1, (k >= 15), (k == 15), 1'b0, (k == 25), 1'b0);
      act = observed();
      total++;
      if (act !== exp) begin
        bad++;
        $display("FAIL bounce k=%0d got=%05h want=%05h", k, act, exp);
      end
    end
  endtask

  task automatic test_short_and_norepeat();
    logic [19:0] act;
    logic [19:0] exp;
    apply_reset();
    repeat_en = 4'hF;
    for (int k = 0; k <= 30; k++) begin
      keys[2] = (k <= 8) ? 1'b0 : 1'b1;
      @(negedge clk);
      exp = key_bits(2, (k >= 5 && k <= 13), (k == 5), (k == 14), 1'b0, 1'b0);
      act = observed();
      total++;
      if (act !== exp) begin
        bad++;
        $display("FAIL short k=%0d got=%05h want=%05h", k, act, exp);
      end
    end
    apply_reset();
    repeat_en = 4'b1011;
    for (int k = 0; k <= 40; k++) begin
      keys[2] = 1'b0;
      @(negedge clk);
      exp = key_bits(2, (k >= 5), (k == 5), 1'b0, (k == 15), 1'b0);
      act = observed();
      total++;
      if (act !== exp) begin
        bad++;
        $display("FAIL norepeat k=%0d got=%05h want=%05h", k, act, exp);
      end
    end
  endtask

  task automatic test_all_keys();
    logic [19:0] act;
    logic [19:0] exp;
    apply_reset();
    repeat_en = 4'hF;
    for (int k = 0; k <= 40; k++) begin
      keys = (k >= 20) ? 4'b1000 : 4'b0000;
      @(negedge clk);
      exp = 20'h00000;
      for (int i = 0; i < 3; i++) begin
        exp = exp | key_bits(i, (k >= 5), (k == 5), 1'b0, (k == 15),
                             on_grid(k, 18, 40));
      end
      exp = exp | key_bits(3, (k >= 5 && k <= 24), (k == 5), (k == 25),
                           (k == 15), on_grid(k, 18, 24));
      act = observed();
      total++;
      if (act !== exp) begin
        bad++;
        $display("FAIL allkeys k=%0d got=%05h want=%05h", k, act, exp);
      end
    end
  endtask

  task automatic test_reenable();
    logic [19:0] act;
    logic [19:0] exp;
    apply_reset();
    for (int k = 0; k <= 35; k++) begin
      keys[0]      = 1'b0;
      repeat_en[0] = (k >= 23) ? 1'b1 : 1'b0;
      @(negedge clk);
      exp = key_bits(0, (k >= 5), (k == 5), 1'b0, (k == 15),
                     on_grid(k, 25, 35));
      act = observed();
      total++;
      if (act !== exp) begin
        bad++;
        $display("FAIL reenable k=%0d got=%05h want=%05h", k, act, exp);
      end
    end
  endtask

  task automatic test_reset_mid_hold();
    logic [19:0] act;
    logic [19:0] exp;
    apply_reset();
    repeat_en = 4'b0001;
    for (int k = 0; k <= 20; k++) begin
      keys[0] = 1'b0;
      @(negedge clk);
      exp = key_bits(0, (k >= 5), (k == 5), 1'b0, (k == 15),
                     on_grid(k, 18, 20));
      act = observed();
      total++;
      if (act !== exp) begin
        bad++;
        $display("FAIL prehold k=%0d got=%05h want=%05h", k, act, exp);
      end
    end
    rst_n = 1'b0;
    #1;
    act = observed();
    total++;
    if (act !== 20'h00000) begin
      bad++;
      $display("FAIL async_clear got=%05h want=%05h", act, 20'h00000);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k <= 25; k++) begin
      @(negedge clk);
      exp = key_bits(0, (k >= 5), (k == 5), 1'b0, (k == 15),
                     on_grid(k, 18, 25));
      act = observed();
      total++;
      if (act !== exp) begin
        bad++;
        $display("FAIL posthold k=%0d got=%05h want=%05h", k, act, exp);
      end
    end
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst_n     = 1'b0;
    keys      = 4'hF;
    repeat_en = 4'h0;
    test_reset();
    test_single_key();
    test_bounce();
    test_short_and_norepeat();
    test_all_keys();
    test_reenable();
    test_reset_mid_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
